conv_mac_acc: RTL and testbench

//  Producer side of the conv-layer accumulator interface: streams signed 8-bit pixel/weight

---
 rtl/conv_mac_acc.sv | 105 ++++++++++
 tb/tb_conv_mac_acc.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_acc.sv
// Conv-layer window accumulator: multiply-accumulates signed pixel/weight beats plus a bias
// into a signed 64-bit sum, then holds that sum on a valid/ready output until it is consumed.
module conv_mac_acc #(
  parameter int DATA_W     = 8,
  parameter int BIAS_W     = 32,
  parameter int ACC_W      = 64,
  parameter int KERNEL_LEN = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pix,
  input  logic [DATA_W-1:0] in_wgt,
  input  logic              in_last,
  input  logic [BIAS_W-1:0] bias,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              len_err
);

  localparam int CNT_W  = 8;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_data_q;
  logic               in_ready_q;
  logic               acc_valid_q;
  logic               len_err_q;

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W:0]     count_d;
  logic               beat_acc;
  logic               close_win;

  always_comb begin
    prod      = PROD_W'($signed(in_pix)) * PROD_W'($signed(in_wgt));
    prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext  = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    // Bias is folded in on the first beat so a 1-tap window still carries it.
    acc_d     = ((count_q == '0) ? bias_ext : acc_q) + prod_ext;
    count_d   = {1'b0, count_q} + (CNT_W+1)'(1);
    beat_acc  = (state_q == ST_ACC) && in_valid;
    close_win = (count_d == (CNT_W+1)'(KERNEL_LEN)) || in_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      count_q     <= '0;
      acc_q       <= '0;
      acc_data_q  <= '0;
      in_ready_q  <= 1'b1;
      acc_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (beat_acc) begin
            acc_q <= acc_d;
            if (close_win) begin
              state_q     <= ST_OUT;
              count_q     <= '0;
              acc_data_q  <= acc_d;
              in_ready_q  <= 1'b0;
              acc_valid_q <= 1'b1;
              len_err_q   <= (count_d != (CNT_W+1)'(KERNEL_LEN));
            end else begin
              count_q <= count_d[CNT_W-1:0];
            end
          end
        end
        ST_OUT: begin
          if (acc_ready) begin
            state_q     <= ST_ACC;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            acc_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign acc_valid = acc_valid_q;
  assign acc_data  = acc_data_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_conv_mac_acc.sv
// Self-checking bench for conv_mac_acc: directed scenarios plus randomized windows checked
// against a plain-arithmetic sum of bias and pixel*weight products.
module tb_conv_mac_acc;

  localparam int KL = 9;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pix;
  logic [7:0]  in_wgt;
  logic        in_last;
  logic [31:0] bias;
  logic        acc_valid;
  logic        acc_ready;
  logic [63:0] acc_data;
  logic        len_err;

  int checks;
  int failures;

  logic signed [7:0] pix_a [0:255];
  logic signed [7:0] wgt_a [0:255];

  conv_mac_acc #(
    .DATA_W(8), .BIAS_W(32), .ACC_W(64), .KERNEL_LEN(KL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .in_wgt(in_wgt), .in_last(in_last), .bias(bias),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bias plus the first n products, two's complement wrapping at 64 bits.
  function automatic longint model_sum(input int n, input logic [31:0] b);
    longint s;
    s = longint'($signed(b));
    for (int i = 0; i < n; i++)
      s = s + longint'(pix_a[i]) * longint'(wgt_a[i]);
    return s;
  endfunction

  // Drives n beats starting and ending on a negedge; bias is randomized after the first beat
  // so only the first-beat value may influence the sum.
  task automatic drive_window(input int n, input bit last_on_final, input logic [31:0] b,
                              input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_pix   = pix_a[i];
      in_wgt   = wgt_a[i];
      in_last  = last_on_final && (i == n - 1);
      bias     = (i == 0) ? b : 32'($urandom);
      begin
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
          @(negedge clk);
          w++;
        end
        if (w >= 50) begin
          checks++;
          failures++;
          $display("FAIL drive_timeout in_ready=%0b required=1", in_ready);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic fill(input int n, input int pix, input int wgt);
    for (int i = 0; i < n; i++) begin
      pix_a[i] = 8'(pix);
      wgt_a[i] = 8'(wgt);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      pix_a[i] = 8'($urandom);
      wgt_a[i] = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || acc_valid !== 1'b0 || acc_data !== 64'd0 || len_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%0b vld=%0b data=%0h err=%0b required 1 0 0 0",
               in_ready, acc_valid, acc_data, len_err);
    end
  endtask

  task automatic test_ones();
    acc_ready = 1'b1;
    fill(KL, 1, 1);
    drive_window(KL, 1'b0, 32'd0, 0);
    checks++;
    if (acc_valid !== 1'b1 || acc_data !== 64'd9 || len_err !== 1'b0) begin
      failures++;
      $display("FAIL ones_window got vld=%0b data=%0d err=%0b required 1 9 0",
               acc_valid, $signed(acc_data), len_err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ones_bubble in_ready=%0b required=0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (acc_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ones_release got vld=%0b rdy=%0b required 0 1", acc_valid, in_ready);
    end
  endtask

  task automatic test_extremes();
    acc_ready = 1'b1;
    fill(KL, -128, 127);
    drive_window(KL, 1'b0, -32'sd5, 0);
    checks++;
    if (acc_valid !== 1'b1 || acc_data !== 64'(-64'sd146309) || len_err !== 1'b0) begin
      failures++;
      $display("FAIL extremes got vld=%0b data=%0d err=%0b required 1 -146309 0",
               acc_valid, $signed(acc_data), len_err);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    longint exp;
    bit bad;
    acc_ready = 1'b0;
    fill_random(KL);
    drive_window(KL, 1'b0, 32'd1000, 0);
    exp  = model_sum(KL, 32'd1000);
    held = acc_data;
    checks++;
    if (acc_valid !== 1'b1 || acc_data !== 64'(exp)) begin
      failures++;
      $display("FAIL bp_data got vld=%0b data=%0d required 1 %0d", acc_valid, $signed(acc_data), exp);
    end
    // Offer a beat while the sum is pending; it must not be taken.
    in_valid = 1'b1;
    in_pix   = 8'd100;
    in_wgt   = 8'd100;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (acc_valid !== 1'b1 || in_ready !== 1'b0 || acc_data !== held) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold got vld=%0b rdy=%0b data=%0h required 1 0 %0h",
               acc_valid, in_ready, acc_data, held);
    end
    acc_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got rdy=%0b vld=%0b required 1 0", in_ready, acc_valid);
    end
  endtask

  task automatic test_early_last();
    acc_ready = 1'b1;
    fill(4, 2, 3);
    drive_window(4, 1'b1, 32'd10, 0);
    checks++;
    if (acc_valid !== 1'b1 || acc_data !== 64'd34 || len_err !== 1'b1) begin
      failures++;
      $display("FAIL early_last got vld=%0b data=%0d err=%0b required 1 34 1",
               acc_valid, $signed(acc_data), len_err);
    end
    @(negedge clk);
    fill(KL, 3, -2);
    drive_window(KL, 1'b0, 32'd7, 0);
    checks++;
    if (acc_data !== 64'(-64'sd47) || len_err !== 1'b0) begin
      failures++;
      $display("FAIL after_early got data=%0d err=%0b required -47 0", $signed(acc_data), len_err);
    end
    @(negedge clk);
    // Single-tap window and in_last coinciding with a full window.
    fill(1, -7, 9);
    drive_window(1, 1'b1, 32'd3, 0);
    checks++;
    if (acc_data !== 64'(-64'sd60) || len_err !== 1'b1) begin
      failures++;
      $display("FAIL one_tap got data=%0d err=%0b required -60 1", $signed(acc_data), len_err);
    end
    @(negedge clk);
    fill(KL, 1, 2);
    drive_window(KL, 1'b1, 32'd0, 0);
    checks++;
    if (acc_data !== 64'd18 || len_err !== 1'b0) begin
      failures++;
      $display("FAIL last_at_full got data=%0d err=%0b required 18 0", $signed(acc_data), len_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    acc_ready = 1'b1;
    fill(5, 50, 50);
    drive_window(5, 1'b0, 32'd123, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (acc_valid !== 1'b0 || in_ready !== 1'b1 || acc_data !== 64'd0) begin
      failures++;
      $display("FAIL rst_mid got vld=%0b rdy=%0b data=%0h required 0 1 0", acc_valid, in_ready, acc_data);
    end
    fill(KL, 1, -1);
    drive_window(KL, 1'b0, 32'd0, 0);
    checks++;
    if (acc_data !== 64'(-64'sd9) || len_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_fresh got data=%0d err=%0b required -9 0", $signed(acc_data), len_err);
    end
    @(negedge clk);
    // Reset while a short-window sum is pending.
    acc_ready = 1'b0;
    fill(2, 4, 4);
    drive_window(2, 1'b1, 32'd0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (acc_valid !== 1'b0 || in_ready !== 1'b1 || len_err !== 1'b0 || acc_data !== 64'd0) begin
      failures++;
      $display("FAIL rst_out got vld=%0b rdy=%0b err=%0b data=%0h required 0 1 0 0",
               acc_valid, in_ready, len_err, acc_data);
    end
    acc_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    longint exp;
    logic [31:0] b;
    acc_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      fill_random(KL);
      b = 32'($urandom);
      drive_window(KL, 1'b0, b, 30);
      exp = model_sum(KL, b);
      checks++;
      if (acc_valid !== 1'b1 || acc_data !== 64'(exp) || len_err !== 1'b0) begin
        failures++;
        $display("FAIL b2b_w%0d got vld=%0b data=%0d err=%0b required 1 %0d 0",
                 w, acc_valid, $signed(acc_data), len_err, exp);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_bubble_w%0d in_ready=%0b required=0", w, in_ready);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || acc_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_reopen_w%0d got rdy=%0b vld=%0b required 1 0", w, in_ready, acc_valid);
      end
    end
  endtask

  task automatic test_random_len();
    longint exp;
    logic [31:0] b;
    int n;
    int d;
    bit last_f;
    for (int w = 0; w < 12; w++) begin
      acc_ready = 1'b0;
      n = $urandom_range(KL, 1);
      last_f = (n < KL) ? 1'b1 : 1'($urandom_range(1, 0));
      fill_random(n);
      b = 32'($urandom);
      drive_window(n, last_f, b, 20);
      exp = model_sum(n, b);
      checks++;
      if (acc_valid !== 1'b1 || acc_data !== 64'(exp) || len_err !== (n != KL)) begin
        failures++;
        $display("FAIL rnd_w%0d n=%0d got vld=%0b data=%0d err=%0b required 1 %0d %0b",
                 w, n, acc_valid, $signed(acc_data), len_err, exp, (n != KL));
      end
      d = $urandom_range(3, 0);
      repeat (d) @(negedge clk);
      acc_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || acc_valid !== 1'b0) begin
        failures++;
        $display("FAIL rnd_release_w%0d got rdy=%0b vld=%0b required 1 0", w, in_ready, acc_valid);
      end
    end
    acc_ready = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pix    = 8'd0;
    in_wgt    = 8'd0;
    in_last   = 1'b0;
    bias      = 32'd0;
    acc_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_ones();
    test_extremes();
    test_backpressure();
    test_early_last();
    test_reset_mid();
    test_back_to_back();
    test_random_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
